// File: rtl/simd_dot_acc.sv
// ---------------------------------------------------------------------------
// simd_dot_acc
//   Packed-SIMD dot product with an optional running accumulator.
//   Three register stages:
//     S1: per-lane (EW+1)x(EW+1) signed products
//     S2: exact adder-tree sum of the lane products
//     S3: DOT / DOTACC / LOAD / CLR against the accumulator, result register
//   The block accepts one operation per cycle and applies no back-pressure.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   valid_i, op_i            operation strobe and opcode (00 DOT, 01 DOTACC,
//                            10 LOAD, 11 CLR)
//   signed_a_i, signed_b_i   per-operand signedness of the packed elements
//   operand_a_i/operand_b_i  packed elements, lane k = bits [(k+1)*EW-1:k*EW]
//   trans_id_i               tag carried alongside the operation
//   flush_i                  kills every operation still in S1/S2/S3 transit
//   ready_o                  constant 1
//   valid_o, result_o,       returned operation; result_o and trans_id_o
//   trans_id_o               hold their value while valid_o is low
// ---------------------------------------------------------------------------
module simd_dot_acc #(
    parameter int XLEN  = 32,
    parameter int LANES = 4,
    parameter int ACC_W = 32,
    parameter int SAT   = 1,
    parameter int TID_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [1:0]       op_i,
    input  logic             signed_a_i,
    input  logic             signed_b_i,
    input  logic [XLEN-1:0]  operand_a_i,
    input  logic [XLEN-1:0]  operand_b_i,
    input  logic [TID_W-1:0] trans_id_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TID_W-1:0] trans_id_o
);

    localparam int EW    = XLEN / LANES;
    localparam int PW    = 2 * EW + 2;
    localparam int SUM_W = PW + $clog2(LANES);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_DOT    = 2'b00,
        OP_DOTACC = 2'b01,
        OP_LOAD   = 2'b10,
        OP_CLR    = 2'b11
    } op_e;

    // A flush in the same cycle wins over a new operation.
    logic accept;
    logic adv_s2;
    logic adv_s3;

    assign accept = valid_i & ~flush_i;

    // ------------------------------------------------------------------ S1
    logic signed [PW-1:0] prod_next [LANES];
    logic signed [PW-1:0] prod_reg  [LANES];
    logic                 valid_s1_reg;
    op_e                  op_s1_reg;
    logic [TID_W-1:0]     tid_s1_reg;
    logic [XLEN-1:0]      load_s1_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [EW:0] a_ext;
        logic signed [EW:0] b_ext;
        // One extra bit per element lets a single signed multiplier cover
        // every signed/unsigned operand combination exactly.
        assign a_ext = {signed_a_i & operand_a_i[(gi+1)*EW-1], operand_a_i[gi*EW +: EW]};
        assign b_ext = {signed_b_i & operand_b_i[(gi+1)*EW-1], operand_b_i[gi*EW +: EW]};
        assign prod_next[gi] = PW'(a_ext) * PW'(b_ext);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_s1_reg <= 1'b0;
            op_s1_reg    <= OP_DOT;
            tid_s1_reg   <= '0;
            load_s1_reg  <= '0;
            for (int i = 0; i < LANES; i++) begin
                prod_reg[i] <= '0;
            end
        end else begin
            valid_s1_reg <= accept;
            if (accept) begin
                op_s1_reg   <= op_e'(op_i);
                tid_s1_reg  <= trans_id_i;
                load_s1_reg <= operand_a_i;
                for (int i = 0; i < LANES; i++) begin
                    prod_reg[i] <= prod_next[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------ S2
    logic signed [SUM_W-1:0] sum_next;
    logic signed [SUM_W-1:0] sum_s2_reg;
    logic                    valid_s2_reg;
    op_e                     op_s2_reg;
    logic [TID_W-1:0]        tid_s2_reg;
    logic [XLEN-1:0]         load_s2_reg;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_next = sum_next + SUM_W'(prod_reg[i]);
        end
    end

    assign adv_s2 = valid_s1_reg & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_s2_reg <= 1'b0;
            op_s2_reg    <= OP_DOT;
            tid_s2_reg   <= '0;
            load_s2_reg  <= '0;
            sum_s2_reg   <= '0;
        end else begin
            valid_s2_reg <= adv_s2;
            if (adv_s2) begin
                op_s2_reg   <= op_s1_reg;
                tid_s2_reg  <= tid_s1_reg;
                load_s2_reg <= load_s1_reg;
                sum_s2_reg  <= sum_next;
            end
        end
    end

    // ------------------------------------------------------------------ S3
    logic signed [ACC_W:0]   sum_ext;
    logic signed [ACC_W:0]   acc_sum;
    logic signed [ACC_W-1:0] acc_sat;
    logic signed [ACC_W-1:0] load_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] result_next;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] result_reg;
    logic                    valid_s3_reg;
    logic [TID_W-1:0]        tid_s3_reg;

    // One guard bit above the accumulator detects overflow of acc + sum.
    assign sum_ext  = (ACC_W+1)'(sum_s2_reg);
    assign acc_sum  = (ACC_W+1)'(acc_reg) + sum_ext;
    assign load_ext = ACC_W'($signed(load_s2_reg));

    always_comb begin
        acc_sat = acc_sum[ACC_W-1:0];
        if ((SAT != 0) && (acc_sum[ACC_W] != acc_sum[ACC_W-1])) begin
            acc_sat = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        acc_next    = acc_reg;
        result_next = acc_reg;
        case (op_s2_reg)
            OP_DOT:    result_next = ACC_W'(sum_s2_reg);
            OP_DOTACC: begin
                acc_next    = acc_sat;
                result_next = acc_sat;
            end
            OP_LOAD:   begin
                acc_next    = load_ext;
                result_next = load_ext;
            end
            OP_CLR:    begin
                acc_next    = '0;
                result_next = '0;
            end
            default:   ;
        endcase
    end

    // Flush suppresses the S3 capture too, so the accumulator is untouched.
    assign adv_s3 = valid_s2_reg & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_s3_reg <= 1'b0;
            acc_reg      <= '0;
            result_reg   <= '0;
            tid_s3_reg   <= '0;
        end else begin
            valid_s3_reg <= adv_s3;
            if (adv_s3) begin
                acc_reg    <= acc_next;
                result_reg <= result_next;
                tid_s3_reg <= tid_s2_reg;
            end
        end
    end

    assign ready_o    = 1'b1;
    assign valid_o    = valid_s3_reg;
    assign result_o   = XLEN'(result_reg);
    assign trans_id_o = tid_s3_reg;

endmodule

// File: tb/tb_simd_dot_acc.sv
// ---------------------------------------------------------------------------
// tb_simd_dot_acc
//   Two instances share all inputs: one saturating, one wrapping.
//   A timestamped queue model predicts each returned result; a compare
//   process checks every cycle, and directed sequences pin literal values.
// ---------------------------------------------------------------------------
module tb_simd_dot_acc;

    localparam int XLEN  = 32;
    localparam int LANES = 4;
    localparam int ACC_W = 32;
    localparam int TID_W = 3;
    localparam int EW    = XLEN / LANES;

    localparam logic [1:0] DOT    = 2'b00;
    localparam logic [1:0] DOTACC = 2'b01;
    localparam logic [1:0] LOAD   = 2'b10;
    localparam logic [1:0] CLR    = 2'b11;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid = 1'b0;
    logic [1:0]       op    = 2'b00;
    logic             sa    = 1'b0;
    logic             sb    = 1'b0;
    logic [XLEN-1:0]  a     = '0;
    logic [XLEN-1:0]  b     = '0;
    logic [TID_W-1:0] tid   = '0;
    logic             flush = 1'b0;

    logic             ready0, valid0, ready1, valid1;
    logic [XLEN-1:0]  res0, res1;
    logic [TID_W-1:0] tid0, tid1;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    simd_dot_acc #(.XLEN(XLEN), .LANES(LANES), .ACC_W(ACC_W), .SAT(1), .TID_W(TID_W)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .op_i(op),
        .signed_a_i(sa), .signed_b_i(sb), .operand_a_i(a), .operand_b_i(b),
        .trans_id_i(tid), .flush_i(flush), .ready_o(ready0), .valid_o(valid0),
        .result_o(res0), .trans_id_o(tid0)
    );

    simd_dot_acc #(.XLEN(XLEN), .LANES(LANES), .ACC_W(ACC_W), .SAT(0), .TID_W(TID_W)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .op_i(op),
        .signed_a_i(sa), .signed_b_i(sb), .operand_a_i(a), .operand_b_i(b),
        .trans_id_i(tid), .flush_i(flush), .ready_o(ready1), .valid_o(valid1),
        .result_o(res1), .trans_id_o(tid1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------ model
    function automatic longint sx(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (((m >> (w - 1)) & 1) != 0) m = m - (longint'(1) << w);
        return m;
    endfunction

    function automatic longint dotsum(input logic s_a, input logic s_b,
                                      input logic [XLEN-1:0] va, input logic [XLEN-1:0] vb);
        longint s, ea, eb;
        s = 0;
        for (int k = 0; k < LANES; k++) begin
            ea = longint'(va[k*EW +: EW]);
            eb = longint'(vb[k*EW +: EW]);
            if (s_a) ea = sx(ea, EW);
            if (s_b) eb = sx(eb, EW);
            s = s + ea * eb;
        end
        return s;
    endfunction

    typedef struct {
        int               issue;
        logic [1:0]       op;
        logic             sa;
        logic             sb;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TID_W-1:0] tid;
    } op_t;

    op_t              pend[$];
    longint           acc_s   = 0;
    longint           acc_w   = 0;
    logic             exp_v   = 1'b0;
    logic [XLEN-1:0]  exp_r_s = '0;
    logic [XLEN-1:0]  exp_r_w = '0;
    logic [TID_W-1:0] exp_t   = '0;
    int               cyc     = 0;

    // An operation issued in cycle t retires at the end of t+2 unless a
    // flush arrives in t, t+1 or t+2; it is then visible in cycle t+3.
    always @(posedge clk or negedge rst_n) begin
        op_t    o;
        longint s, v, mx, mn;
        if (!rst_n) begin
            pend.delete();
            acc_s = 0; acc_w = 0; exp_v = 1'b0;
            exp_r_s = '0; exp_r_w = '0; exp_t = '0; cyc = 0;
        end else begin
            exp_v = 1'b0;
            if (flush) begin
                pend.delete();
            end else begin
                if (valid) pend.push_back('{cyc, op, sa, sb, a, b, tid});
                if (pend.size() > 0 && pend[0].issue == cyc - 2) begin
                    o  = pend.pop_front();
                    s  = dotsum(o.sa, o.sb, o.a, o.b);
                    mx = (longint'(1) << (ACC_W - 1)) - 1;
                    mn = -(longint'(1) << (ACC_W - 1));
                    case (o.op)
                        DOT: begin
                            exp_r_s = XLEN'(sx(s, ACC_W));
                            exp_r_w = XLEN'(sx(s, ACC_W));
                        end
                        DOTACC: begin
                            acc_s = acc_s + s;
                            if (acc_s > mx) acc_s = mx;
                            if (acc_s < mn) acc_s = mn;
                            acc_w = sx(acc_w + s, ACC_W);
                            exp_r_s = XLEN'(acc_s);
                            exp_r_w = XLEN'(acc_w);
                        end
                        LOAD: begin
                            v = sx(sx(longint'(o.a), XLEN), ACC_W);
                            acc_s = v; acc_w = v;
                            exp_r_s = XLEN'(v);
                            exp_r_w = XLEN'(v);
                        end
                        default: begin
                            acc_s = 0; acc_w = 0;
                            exp_r_s = '0; exp_r_w = '0;
                        end
                    endcase
                    exp_t = o.tid;
                    exp_v = 1'b1;
                end
            end
            cyc++;
        end
    end

    // ------------------------------------------------------------ compare
    always @(posedge clk) begin
        #1;
        chk("valid_sat",  valid0,  exp_v);
        chk("valid_wrap", valid1,  exp_v);
        chk("ready",      {ready0, ready1}, 2'b11);
        chk("result_sat", res0,    exp_r_s);
        chk("result_wrap", res1,   exp_r_w);
        chk("tid_sat",    tid0,    exp_t);
        chk("tid_wrap",   tid1,    exp_t);
    end

    // ------------------------------------------------------------ stimulus
    task automatic send(input logic [1:0] o, input logic s_a, input logic s_b,
                        input logic [XLEN-1:0] va, input logic [XLEN-1:0] vb,
                        input logic [TID_W-1:0] t);
        valid = 1'b1; op = o; sa = s_a; sb = s_b; a = va; b = vb; tid = t;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        chk("model_pin_signed", dotsum(1'b1, 1'b1, 32'h7F7F7F7F, 32'hFFFFFFFF), 64'hFFFFFFFF_FFFFFE04);
        chk("model_pin_unsigned", dotsum(1'b0, 1'b0, 32'hFFFFFFFF, 32'h01010101), 64'd1020);

        repeat (2) @(negedge clk);
        chk("reset_valid",  {valid0, valid1}, 2'b00);
        chk("reset_result", res0, 32'h0);
        chk("reset_tid",    tid0, 3'd0);
        chk("reset_ready",  ready0, 1'b1);
        rst_n = 1'b1;

        // Signed/unsigned DOT cases
        send(DOT, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h01010101, 3'd1);
        repeat (2) @(negedge clk);
        chk("dot_sa_valid", valid0, 1'b1);
        chk("dot_sa", res0, 32'hFFFFFFFC);
        chk("dot_sa_tid", tid0, 3'd1);
        send(DOT, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h01010101, 3'd2);
        repeat (2) @(negedge clk);
        chk("dot_ua", res0, 32'h000003FC);
        send(DOT, 1'b1, 1'b1, 32'h7F7F7F7F, 32'hFFFFFFFF, 3'd3);
        repeat (2) @(negedge clk);
        chk("dot_ss", res0, 32'hFFFFFE04);
        send(DOT, 1'b1, 1'b0, 32'h7F7F7F7F, 32'hFFFFFFFF, 3'd4);
        repeat (2) @(negedge clk);
        chk("dot_su", res0, 32'h0001FA04);
        @(negedge clk);
        chk("hold_valid", valid0, 1'b0);
        chk("hold_result", res0, 32'h0001FA04);

        // Back-to-back accumulation chain
        send(CLR, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        send(DOTACC, 1'b0, 1'b0, 32'h01010101, 32'h02020202, 3'd1);
        send(DOTACC, 1'b0, 1'b0, 32'h01010101, 32'h02020202, 3'd2);
        send(DOTACC, 1'b0, 1'b0, 32'h01010101, 32'h02020202, 3'd3);
        chk("chain1", res0, 32'd8);
        chk("chain1_tid", tid0, 3'd1);
        @(negedge clk);
        chk("chain2", res0, 32'd16);
        chk("chain2_tid", tid0, 3'd2);
        @(negedge clk);
        chk("chain3", res0, 32'd24);
        chk("chain3_tid", tid0, 3'd3);

        // Saturating versus wrapping overflow
        send(LOAD, 1'b0, 1'b0, 32'h7FFFFFF0, 32'h0, 3'd5);
        send(DOTACC, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h01010101, 3'd6);
        @(negedge clk);
        chk("load_sat", res0, 32'h7FFFFFF0);
        chk("load_wrap", res1, 32'h7FFFFFF0);
        @(negedge clk);
        chk("ovf_sat", res0, 32'h7FFFFFFF);
        chk("ovf_wrap", res1, 32'h800003EC);

        // Flush with three DOTACC in flight
        send(CLR, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        send(DOTACC, 1'b0, 1'b0, 32'h01010101, 32'h01010101, 3'd1);
        send(DOTACC, 1'b0, 1'b0, 32'h01010101, 32'h01010101, 3'd2);
        send(DOTACC, 1'b0, 1'b0, 32'h01010101, 32'h01010101, 3'd3);
        flush = 1'b1;
        chk("flush_first_valid", valid0, 1'b1);
        chk("flush_first", res0, 32'd4);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_kill2", valid0, 1'b0);
        chk("flush_hold_tid", tid0, 3'd1);
        @(negedge clk);
        chk("flush_kill3", valid0, 1'b0);
        send(DOTACC, 1'b0, 1'b0, 32'h01010101, 32'h01010101, 3'd4);
        repeat (2) @(negedge clk);
        chk("flush_acc_kept", res0, 32'd8);

        // Reset with a full pipeline
        send(DOTACC, 1'b0, 1'b0, 32'h01010101, 32'h01010101, 3'd1);
        send(DOTACC, 1'b0, 1'b0, 32'h01010101, 32'h01010101, 3'd2);
        send(DOTACC, 1'b0, 1'b0, 32'h01010101, 32'h01010101, 3'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_valid_now", {valid0, valid1}, 2'b00);
        chk("rst_result_now", res0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(DOTACC, 1'b0, 1'b0, 32'h01010101, 32'h01010101, 3'd5);
        repeat (2) @(negedge clk);
        chk("rst_acc_cleared", res0, 32'd4);
        chk("rst_acc_tid", tid0, 3'd5);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            valid = ($urandom_range(0, 9) < 8);
            op    = 2'($urandom_range(0, 3));
            sa    = 1'($urandom_range(0, 1));
            sb    = 1'($urandom_range(0, 1));
            a     = $urandom;
            b     = $urandom;
            tid   = TID_W'($urandom_range(0, 7));
            flush = ($urandom_range(0, 19) == 0);
            if (op == LOAD && $urandom_range(0, 1) == 1)
                a = ($urandom_range(0, 1) == 1) ? 32'h7FFF0000 + 32'($urandom_range(0, 65535))
                                                : 32'h80000000 + 32'($urandom_range(0, 65535));
            if (n == 200) rst_n = 1'b0;
            if (n == 202) rst_n = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
        flush = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
